mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data bus width (32 or 64).
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter TIMEOUT, default 255, maximum ack-wait cycles before bus error (1..65535).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock, all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 valid_i  in  1  memory operation presented this cycle.
REQ-008 rd_i / wr_i  in  1 each  load / store request; both high is illegal and is treated as a load.
REQ-009 size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
REQ-010 sign_i  in  1  sign-extend load result.
REQ-011 addr_i  in  ADDR_W  byte address.
REQ-012 wdata_i  in  DATA_W  store data, right-aligned.
REQ-013 kill_i  in  1  upstream exception/flush; suppresses the access.
REQ-014 bus_req_o, bus_we_o  out  1  bus request, write enable.
REQ-015 bus_addr_o  out  ADDR_W  address, aligned down to DATA_W/8 bytes.
REQ-016 bus_sel_o  out  DATA_W/8  byte lanes.
REQ-017 bus_wdata_o  out  DATA_W  lane-replicated store data.
REQ-018 bus_ack_i  in  1  / bus_rdata_i  in  DATA_W  completion and read data.
REQ-019 stall_o  out  1  holds upstream pipeline.
REQ-020 done_o  out  1  one-cycle completion pulse; rdata_o  out  DATA_W  extended load result.
REQ-021 exc_o  out  2  0 none, 1 load misaligned (AdEL), 2 store misaligned (AdES), 3 bus error/timeout.

Function
REQ-022 FSM states IDLE, REQ, WAIT, RESP; reset state IDLE.
REQ-023 IDLE: on valid_i&(rd_i|wr_i)&~kill_i&aligned, capture op into registers, go REQ, assert stall_o combinationally that cycle.
REQ-024 Alignment: address low bits must be zero for the size (half: bit0, word: bits1:0, dword: bits2:0); on violation exc_o = AdEL/AdES with done_o for one cycle, no bus request, stay IDLE.
REQ-025 size_i=3 with DATA_W=32 is misaligned-class error (AdEL/AdES).
REQ-026 kill_i in IDLE: no request, no exception, no done_o.
REQ-027 REQ: bus_req_o=1 for exactly one cycle with captured addr/we/sel/wdata, then WAIT.
REQ-028 WAIT: on bus_ack_i go RESP, latch bus_rdata_i; each non-ack cycle increments a wait counter; counter reaching TIMEOUT goes RESP with exc_o=3.
REQ-029 RESP: done_o=1, stall_o=0, rdata_o valid for this cycle only; next state IDLE; a new request may be accepted the following cycle (minimum 4-cycle op-to-op).
REQ-030 Latency with ack in first WAIT cycle: done_o 3 cycles after accept.
REQ-031 bus_sel_o: size-wide mask shifted left by addr low bits; dword = all ones.
REQ-032 bus_wdata_o: byte replicated to all lanes, half to all half-lanes, word to both words when DATA_W=64.
REQ-033 Load extract: select lane by addr low bits, then zero- or sign-extend to DATA_W per sign_i.
REQ-034 kill_i while in REQ/WAIT does not abort; access completes (bus ordering preserved) but done_o and exc_o are suppressed, rdata_o is 0.
REQ-035 stall_o = 1 in REQ and WAIT and on accept cycle; 0 otherwise.
REQ-036 bus_ack_i outside WAIT is ignored.

Reset
REQ-037 rst_i returns FSM to IDLE next edge from any state, even mid-WAIT; outstanding ack is dropped.
REQ-038 Reset values: all outputs 0, wait counter 0, captured op registers 0.

Structure
REQ-039 Shared package holds state enum, exc_o code constants, size encodings.
REQ-040 One sub-module mem_lane_align: combinational sel/wdata replicate and load extract, parametrised by DATA_W.
REQ-041 Counter width $clog2(TIMEOUT+1).

Verification
REQ-042 DATA_W=32, lw addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> done_o 5 cycles after accept, rdata_o 0xDEADBEEF.
REQ-043 lb sign addr 0x103, rdata 0x80xxxxxx -> sel 4'b1000 on request, rdata_o 0xFFFFFF80; lbu -> 0x00000080.
REQ-044 sh addr 0x102 data 0x1234 -> sel 4'b1100, wdata 0x12341234; sw addr 0x101 -> exc_o=2, no bus_req_o.
REQ-045 No ack, TIMEOUT=4 -> exc_o=3 with done_o after 4 wait cycles, FSM IDLE next.
REQ-046 DATA_W=64 ld addr 0x8 -> sel 8'hFF; ld addr 0x4 -> exc_o=1; kill_i during WAIT -> no done_o.
REQ-047 rst_i asserted in WAIT -> IDLE, stall_o 0 next cycle, late ack ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ============================================================
// mem_access_unit_pkg : shared states, exception codes, sizes
// Rev 1.0
// ============================================================
`default_nettype none

package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // A dword on a 32-bit bus can never be satisfied, so it reports as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo,
                                      input logic has_dword);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lo[0];
      SZ_WORD: r = |lo[1:0];
      default: r = has_dword ? (|lo) : 1'b1;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================
// mem_access_unit_if : memory bus between access unit and memory
// Rev 1.0
// ============================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                bus_req_o;
  logic                bus_we_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W/8-1:0] bus_sel_o;
  logic [DATA_W-1:0]   bus_wdata_o;
  logic                bus_ack_i;
  logic [DATA_W-1:0]   bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================
// mem_lane_align : byte-lane select, store replicate, load extract
// Rev 1.0
// ============================================================
`default_nettype none

module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int LB    = $clog2(NB)
) (
  input  wire logic [1:0]        i_size,
  input  wire logic [LB-1:0]     i_addr_lo,
  input  wire logic              i_sign,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic [DATA_W-1:0] i_rdata,
  output logic      [NB-1:0]     o_sel,
  output logic      [DATA_W-1:0] o_wdata,
  output logic      [DATA_W-1:0] o_rdata
);

  logic [NB-1:0]     w_lane_mask;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_msb;

  always_comb begin
    w_lane_mask = '1;
    o_wdata     = i_wdata;
    w_mask      = '1;
    w_msb       = 1'b0;
    w_shift     = i_rdata >> {i_addr_lo, 3'b000};
    case (i_size)
      SZ_BYTE: begin
        w_lane_mask = NB'(1);
        o_wdata     = {NB{i_wdata[7:0]}};
        w_mask      = DATA_W'(8'hFF);
        w_msb       = w_shift[7];
      end
      SZ_HALF: begin
        w_lane_mask = NB'(2'b11);
        o_wdata     = {(NB/2){i_wdata[15:0]}};
        w_mask      = DATA_W'(16'hFFFF);
        w_msb       = w_shift[15];
      end
      SZ_WORD: begin
        w_lane_mask = NB'(4'hF);
        o_wdata     = {(NB/4){i_wdata[31:0]}};
        w_mask      = DATA_W'(32'hFFFF_FFFF);
        w_msb       = w_shift[31];
      end
      default: ;
    endcase
    o_sel   = w_lane_mask << i_addr_lo;
    // Sign fill everything above the access width when requested.
    o_rdata = (w_shift & w_mask) | ((i_sign & w_msb) ? ~w_mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================
// mem_access_unit : load/store sequencer with bus ack timeout
// Rev 1.0
// ============================================================
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  input  wire logic              valid_i,
  input  wire logic              rd_i,
  input  wire logic              wr_i,
  input  wire logic [1:0]        size_i,
  input  wire logic              sign_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic              kill_i,
  mem_access_unit_if.master      bus,
  output logic                   stall_o,
  output logic                   done_o,
  output logic      [DATA_W-1:0] rdata_o,
  output logic      [1:0]        exc_o
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_sign, r_killed, r_tmo;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [CW-1:0]     r_cnt;

  logic              w_req, w_we, w_mis, w_accept, w_reject, w_tmo;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NB-1:0]     w_sel;
  logic [DATA_W-1:0] w_wrep, w_ext;

  assign w_req     = valid_i & (rd_i | wr_i) & ~kill_i;
  assign w_we      = wr_i & ~rd_i;
  assign w_mis     = misaligned(size_i, addr_i[2:0], DATA_W == 64);
  assign w_accept  = (r_state == S_IDLE) & w_req & ~w_mis & ~rst_i;
  assign w_reject  = (r_state == S_IDLE) & w_req &  w_mis & ~rst_i;
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_tmo     = ~bus.bus_ack_i & (w_cnt_nxt == CW'(TIMEOUT));

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size    (r_size),
    .i_addr_lo (r_addr[LB-1:0]),
    .i_sign    (r_sign),
    .i_wdata   (r_wdata),
    .i_rdata   (r_rdata),
    .o_sel     (w_sel),
    .o_wdata   (w_wrep),
    .o_rdata   (w_ext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_sign   <= 1'b0;
      r_size   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_killed <= 1'b0;
      r_tmo    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr   <= addr_i;
          r_we     <= w_we;
          r_sign   <= sign_i;
          r_size   <= size_i;
          r_wdata  <= wdata_i;
          r_rdata  <= '0;
          r_killed <= 1'b0;
          r_tmo    <= 1'b0;
        end
        S_REQ:  r_cnt <= '0;
        S_WAIT: begin
          if (bus.bus_ack_i) r_rdata <= bus.bus_rdata_i;
          else               r_cnt   <= w_cnt_nxt;
          if (w_tmo)         r_tmo   <= 1'b1;
        end
        default: ;
      endcase
      // A late flush cannot cancel an issued bus cycle, it only hides the result.
      if ((r_state == S_REQ || r_state == S_WAIT) && kill_i) r_killed <= 1'b1;
    end
  end

  always_comb begin
    w_next          = r_state;
    stall_o         = 1'b0;
    done_o          = 1'b0;
    exc_o           = EXC_NONE;
    rdata_o         = '0;
    bus.bus_req_o   = 1'b0;
    bus.bus_we_o    = 1'b0;
    bus.bus_addr_o  = '0;
    bus.bus_sel_o   = '0;
    bus.bus_wdata_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next  = S_REQ;
          stall_o = 1'b1;
        end else if (w_reject) begin
          done_o = 1'b1;
          exc_o  = w_we ? EXC_ADES : EXC_ADEL;
        end
      end
      S_REQ: begin
        stall_o         = 1'b1;
        bus.bus_req_o   = 1'b1;
        bus.bus_we_o    = r_we;
        bus.bus_addr_o  = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};
        bus.bus_sel_o   = w_sel;
        bus.bus_wdata_o = w_wrep;
        w_next          = S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus.bus_ack_i || w_tmo) w_next = S_RESP;
      end
      default: begin
        w_next = S_IDLE;
        if (!r_killed) begin
          done_o  = 1'b1;
          exc_o   = r_tmo ? EXC_BUS : EXC_NONE;
          rdata_o = (r_tmo | r_we) ? '0 : w_ext;
        end
      end
    endcase
  end

endmodule

`default_nettype wire
